fwd_hazard_tracker: RTL and testbench
=====================================

// Module: fwd_hazard_tracker
// PURPOSE
//  Parametrised successor to the two-operand EX-stage forward unit. It keeps its own pipeline of
//  destination tags (EX..last writeback stage) and produces per-operand forward selects for EX.
//  It also detects load-use hazards against the instruction in ID and generates the stall/bubble.
//  It honours external stall and branch-mispredict flush, and keeps a saturating stall counter.
//  Sits beside the ID/EX pipeline register; drives the EX operand muxes and the IF/ID hold enable.
// PARAMETERS
//  NUM_SRC   2   source operands per instruction (rs1, rs2, ...)
//  DEPTH     3   tracked stages: index 0=EX, 1=MEM, ..., DEPTH-1=WB; legal 2..6
//  AW        5   register address width
//  CNT_W     16  width of stall_count
// PORTS
//  clk             in   1            rising-edge clock
//  reset_n         in   1            asynchronous active-low reset
//  id_valid        in   1            ID holds a valid instruction
//  id_rs_addr      in   NUM_SRC*AW   ID source addresses; src s at [s*AW +: AW]
//  id_rs_used      in   NUM_SRC      src s actually read by ID instruction
//  id_rd_addr      in   AW           ID destination address
//  id_regwrite     in   1            ID instruction writes rd
//  id_is_load      in   1            ID instruction is a load (result ready only at stage DEPTH-1)
//  stall_ext       in   1            external hold (e.g. memory busy): tracker frozen
//  flush           in   1            mispredict: kill instructions in ID and EX
//  fwd_sel         out  NUM_SRC*(DEPTH-1)  one-hot per src; bit (DEPTH-1-k) => forward from stage k
//  load_use_stall  out  1            hold PC/IF/ID, insert bubble into EX
//  stall_count     out  CNT_W        saturating count of load-use stall cycles
// BEHAVIOUR
//  - Entry e[i] = {valid, rd, regwrite, is_load, rs_addr[NUM_SRC], rs_used[NUM_SRC]}; i=0..DEPTH-1.
//  - Reset (async, reset_n=0): all entries invalid, fields 0; fwd_sel=0, load_use_stall=0,
//    stall_count=0. Reset mid-operation discards all in-flight tags immediately.
//  - Fwd match for src s at stage k (1<=k<=DEPTH-1): e[0].valid & e[0].rs_used[s] & e[k].valid &
//    e[k].regwrite & e[k].rd==e[0].rs_addr[s] & e[0].rs_addr[s]!=0.
//  - Priority: the smallest matching k (youngest producer) wins; at most one bit set per src;
//    no match => all zero (regfile). DEPTH=3 gives MEM=2'b10, WB=2'b01, legacy-compatible.
//  - fwd_sel is combinational from registered entries only (no ID-input path), valid in the
//    same cycle the consumer is in EX.
//  - load_use_stall (combinational) = id_valid & e[0].valid & e[0].is_load & e[0].regwrite &
//    e[0].rd!=0 & any s: id_rs_used[s] & id_rs_addr[s]==e[0].rd; forced 0 when flush=1.
//    Generalisation: for DEPTH>3 also stall while a load sits in stages 1..DEPTH-3 and matches.
//  - Update at posedge, priority order:
//    1 stall_ext=1: all entries hold; stall_count holds (flush is ignored while stall_ext=1).
//    2 flush=1: e[1]<=bubble (EX killed), e[0]<=bubble, e[2..]<=e[1..] shifted.
//    3 load_use_stall=1: e[0]<=bubble, e[1..]<=e[0..] shifted; stall_count+=1, saturating at
//      all-ones.
//    4 otherwise: e[0]<=ID fields with valid=id_valid; e[1..]<=e[0..] shifted.
//  - Bubble = valid 0, all fields 0. rd=0 never forwards and never stalls.
//  - Entry at DEPTH-1 retires next cycle; producers writing the regfile in that cycle are covered
//    by write-first regfile (not this block).
//  - Assertion: never a fwd bit set from k=1 when e[1].is_load (stall must have prevented it).
// TESTING
//  1 Reset: hold reset_n=0 with random inputs -> fwd_sel=0, load_use_stall=0, stall_count=0.
//  2 ADD x5 then SUB x6,x5,x5 -> in SUB's EX cycle fwd_sel src0=src1=2'b10.
//  3 ADD x5; NOP; OR x7,x5,x0 -> OR in EX: src0=2'b01, src1=2'b00 (x0 never forwards).
//  4 LW x8; ADD x9,x8,x1 -> one cycle load_use_stall=1, bubble, then ADD in EX with src0=2'b01;
//    stall_count=1.
//  5 Double producer: ADD x5; ADD x5; SUB x1,x5 -> src0=2'b10 (youngest wins).
//  6 flush with LW x8 in EX and dependent in ID -> no stall, e[0],e[1] bubbles; stall_ext=1
//    for 3 cycles freezes fwd_sel and count; stall_count saturates at 2^CNT_W-1.

Source files
------------

// File: rtl/fwd_hazard_tracker.sv
// EX-stage forwarding and load-use hazard tracker.
// Keeps a private pipeline of destination tags from EX to the last writeback stage.
module fwd_hazard_tracker #(
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int AW      = 5,
  parameter int CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         id_valid,
  input  logic [NUM_SRC*AW-1:0]        id_rs_addr,
  input  logic [NUM_SRC-1:0]           id_rs_used,
  input  logic [AW-1:0]                id_rd_addr,
  input  logic                         id_regwrite,
  input  logic                         id_is_load,
  input  logic                         stall_ext,
  input  logic                         flush,
  output logic [NUM_SRC*(DEPTH-1)-1:0] fwd_sel,
  output logic                         load_use_stall,
  output logic [CNT_W-1:0]             stall_count
);

  // Loads in stages 0..LU_LAST are too young to forward to ID's successor.
  localparam int LU_LAST = (DEPTH > 3) ? DEPTH - 3 : 0;

  logic [DEPTH-1:0]      e_vld;
  logic [DEPTH-1:0]      e_wr;
  logic [DEPTH-1:0]      e_ld;
  logic [AW-1:0]         e_rd [DEPTH];
  logic [NUM_SRC*AW-1:0] ex_rs_addr;
  logic [NUM_SRC-1:0]    ex_rs_used;

  logic [NUM_SRC-1:0]    hit;
  logic [AW-1:0]         rs;
  logic [NUM_SRC-1:0]    fwd_k1;
  logic                  unused_ld;

  assign unused_ld = ^e_ld;

  // Youngest matching producer wins per source operand.
  always_comb begin
    fwd_sel = '0;
    hit     = '0;
    fwd_k1  = '0;
    rs      = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      rs = ex_rs_addr[s*AW +: AW];
      for (int k = 1; k < DEPTH; k++) begin
        if (!hit[s] && e_vld[0] && ex_rs_used[s] &&
            e_vld[k] && e_wr[k] &&
            e_rd[k] == rs && rs != '0) begin
          fwd_sel[s*(DEPTH-1) + (DEPTH-1-k)] = 1'b1;
          hit[s] = 1'b1;
          if (k == 1) fwd_k1[s] = 1'b1;
        end
      end
    end
  end

  // Stall ID while a not-yet-ready load produces one of its sources.
  always_comb begin
    load_use_stall = 1'b0;
    for (int k = 0; k <= LU_LAST; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (id_valid && e_vld[k] && e_ld[k] &&
            e_wr[k] && e_rd[k] != '0 &&
            id_rs_used[s] &&
            id_rs_addr[s*AW +: AW] == e_rd[k])
          load_use_stall = 1'b1;
      end
    end
    if (flush) load_use_stall = 1'b0;
  end

  // Tag pipeline: hold, flush, bubble-insert or advance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_vld      <= '0;
      e_wr       <= '0;
      e_ld       <= '0;
      ex_rs_addr <= '0;
      ex_rs_used <= '0;
      for (int k = 0; k < DEPTH; k++) e_rd[k] <= '0;
    end else if (!stall_ext) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        e_vld[k] <= e_vld[k-1];
        e_wr[k]  <= e_wr[k-1];
        e_ld[k]  <= e_ld[k-1];
        e_rd[k]  <= e_rd[k-1];
      end
      if (flush) begin
        e_vld[1] <= 1'b0;
        e_wr[1]  <= 1'b0;
        e_ld[1]  <= 1'b0;
        e_rd[1]  <= '0;
      end
      if (flush || load_use_stall) begin
        e_vld[0]   <= 1'b0;
        e_wr[0]    <= 1'b0;
        e_ld[0]    <= 1'b0;
        e_rd[0]    <= '0;
        ex_rs_addr <= '0;
        ex_rs_used <= '0;
      end else begin
        e_vld[0]   <= id_valid;
        e_wr[0]    <= id_regwrite;
        e_ld[0]    <= id_is_load;
        e_rd[0]    <= id_rd_addr;
        ex_rs_addr <= id_rs_addr;
        ex_rs_used <= id_rs_used;
      end
    end
  end

  // Saturating count of cycles spent in load-use stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      stall_count <= '0;
    else if (!stall_ext && load_use_stall &&
             stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

  // A load in MEM must never be the forward source.
  a_no_mem_load_fwd: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(e_ld[1] && |fwd_k1));

endmodule

// File: tb/tb_fwd_hazard_tracker.sv
// Testbench for fwd_hazard_tracker.
// Instruction-level pipeline model, directed scenarios plus random traffic.
module tb_fwd_hazard_tracker;

  localparam int CW = 4;

  logic          clk;
  logic          reset_n;
  logic          id_valid;
  logic [9:0]    id_rs_addr;
  logic [1:0]    id_rs_used;
  logic [4:0]    id_rd_addr;
  logic          id_regwrite;
  logic          id_is_load;
  logic          stall_ext;
  logic          flush;
  logic [3:0]    fwd_sel;
  logic          load_use_stall;
  logic [CW-1:0] stall_count;

  fwd_hazard_tracker #(
    .NUM_SRC(2), .DEPTH(3), .AW(5), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .id_valid(id_valid),
    .id_rs_addr(id_rs_addr),
    .id_rs_used(id_rs_used),
    .id_rd_addr(id_rd_addr),
    .id_regwrite(id_regwrite),
    .id_is_load(id_is_load),
    .stall_ext(stall_ext),
    .flush(flush),
    .fwd_sel(fwd_sel),
    .load_use_stall(load_use_stall),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic            v;
    logic [4:0]      rd;
    logic            wr;
    logic            ld;
    logic [1:0][4:0] rs;
    logic [1:0]      used;
  } ins_t;

  // Instructions in EX, MEM, WB; index = stage.
  ins_t m [3];
  int   m_cnt;
  ins_t cur;
  bit   cur_se;
  bit   cur_fl;

  int checks = 0;
  int errors = 0;

  function automatic ins_t mk(input bit v, input int rd,
                              input bit wr, input bit ld,
                              input int r1, input bit u1,
                              input int r2, input bit u2);
    ins_t i;
    i.v = v;
    i.rd = 5'(rd);
    i.wr = wr;
    i.ld = ld;
    i.rs[0] = 5'(r1);
    i.rs[1] = 5'(r2);
    i.used = {u2, u1};
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic ins_t rnd_ins();
    return mk($urandom_range(0, 99) < 85,
              $urandom_range(0, 7),
              $urandom_range(0, 99) < 80,
              $urandom_range(0, 99) < 30,
              $urandom_range(0, 7), $urandom_range(0, 1),
              $urandom_range(0, 7), $urandom_range(0, 1));
  endfunction

  // Operand s of EX reads the youngest older writer of its register.
  function automatic logic [3:0] exp_fwd();
    logic [3:0] r;
    r = '0;
    for (int s = 0; s < 2; s++)
      for (int k = 1; k < 3; k++)
        if (r[s*2 +: 2] == 2'b00 && m[0].v && m[0].used[s] &&
            m[k].v && m[k].wr && m[0].rs[s] != 0 &&
            m[k].rd == m[0].rs[s])
          r[s*2 + (2 - k)] = 1'b1;
    return r;
  endfunction

  // ID must wait if it reads what a load in EX is producing.
  function automatic logic exp_stall();
    logic st;
    st = 1'b0;
    for (int s = 0; s < 2; s++)
      if (cur.v && cur.used[s] && m[0].v && m[0].ld &&
          m[0].wr && m[0].rd != 0 && cur.rs[s] == m[0].rd)
        st = 1'b1;
    if (cur_fl) st = 1'b0;
    return st;
  endfunction

  task automatic drive(input ins_t i, input bit se, input bit fl);
    id_valid    = i.v;
    id_rd_addr  = i.rd;
    id_regwrite = i.wr;
    id_is_load  = i.ld;
    id_rs_addr  = i.rs;
    id_rs_used  = i.used;
    stall_ext   = se;
    flush       = fl;
    cur    = i;
    cur_se = se;
    cur_fl = fl;
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 3; k++) m[k] = nop();
    m_cnt = 0;
  endtask

  // Advance one clock and move the instruction model along.
  task automatic tick();
    logic st;
    @(posedge clk);
    st = exp_stall();
    if (!reset_n) begin
      clear_model();
    end else if (!cur_se) begin
      if (cur_fl) begin
        m[2] = m[1];
        m[1] = nop();
        m[0] = nop();
      end else if (st) begin
        m[2] = m[1];
        m[1] = m[0];
        m[0] = nop();
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else begin
        m[2] = m[1];
        m[1] = m[0];
        m[0] = cur;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_model();
    for (int i = 0; i < 4; i++) begin
      drive(rnd_ins(), $urandom_range(0, 1), $urandom_range(0, 1));
      checks++;
      if (fwd_sel !== 4'b0 || load_use_stall !== 1'b0 ||
          stall_count !== '0) begin
        errors++;
        $display("FAIL reset: fwd=%b stall=%b cnt=%0d, want 0/0/0",
                 fwd_sel, load_use_stall, stall_count);
      end
      tick();
    end
    reset_n = 1'b1;
    drive(nop(), 0, 0);
  endtask

  task automatic test_alu_fwd_mem();
    drive(mk(1, 5, 1, 0, 1, 1, 2, 1), 0, 0);
    tick();
    drive(mk(1, 6, 1, 0, 5, 1, 5, 1), 0, 0);
    tick();
    drive(nop(), 0, 0);
    checks++;
    if (fwd_sel !== 4'b1010) begin
      errors++;
      $display("FAIL mem_fwd: fwd=%b want 1010", fwd_sel);
    end
  endtask

  task automatic test_wb_fwd_x0();
    drive(mk(1, 5, 1, 0, 1, 1, 2, 1), 0, 0);
    tick();
    drive(nop(), 0, 0);
    tick();
    drive(mk(1, 7, 1, 0, 5, 1, 0, 1), 0, 0);
    tick();
    drive(nop(), 0, 0);
    checks++;
    if (fwd_sel !== 4'b0001) begin
      errors++;
      $display("FAIL wb_fwd_x0: fwd=%b want 0001", fwd_sel);
    end
  endtask

  task automatic test_load_use();
    drive(mk(1, 8, 1, 1, 2, 1, 0, 0), 0, 0);
    tick();
    drive(mk(1, 9, 1, 0, 8, 1, 1, 1), 0, 0);
    checks++;
    if (load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall: got %b want 1", load_use_stall);
    end
    tick();
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release: got %b want 0", load_use_stall);
    end
    tick();
    drive(nop(), 0, 0);
    checks++;
    if (fwd_sel !== 4'b0001 || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL lu_fwd: fwd=%b cnt=%0d want 0001/1",
               fwd_sel, stall_count);
    end
  endtask

  task automatic test_youngest_wins();
    drive(mk(1, 5, 1, 0, 1, 1, 2, 1), 0, 0);
    tick();
    drive(mk(1, 5, 1, 0, 3, 1, 4, 1), 0, 0);
    tick();
    drive(mk(1, 1, 1, 0, 5, 1, 0, 0), 0, 0);
    tick();
    drive(nop(), 0, 0);
    checks++;
    if (fwd_sel !== 4'b0010) begin
      errors++;
      $display("FAIL youngest: fwd=%b want 0010", fwd_sel);
    end
  endtask

  task automatic test_flush();
    drive(mk(1, 8, 1, 1, 2, 1, 0, 0), 0, 0);
    tick();
    drive(mk(1, 9, 1, 0, 8, 1, 8, 1), 0, 1);
    checks++;
    if (load_use_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b want 0", load_use_stall);
    end
    tick();
    drive(mk(1, 9, 1, 0, 8, 1, 8, 1), 0, 0);
    checks++;
    if (load_use_stall !== 1'b0 || stall_count !== 4'd1) begin
      errors++;
      $display("FAIL flush_bubble: stall=%b cnt=%0d want 0/1",
               load_use_stall, stall_count);
    end
    tick();
  endtask

  task automatic test_stall_ext();
    drive(mk(1, 5, 1, 0, 1, 1, 2, 1), 0, 0);
    tick();
    drive(mk(1, 6, 1, 0, 5, 1, 5, 1), 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(rnd_ins(), 1, $urandom_range(0, 1));
      checks++;
      if (fwd_sel !== 4'b1010) begin
        errors++;
        $display("FAIL ext_freeze_fwd: fwd=%b want 1010", fwd_sel);
      end
      tick();
    end
    drive(mk(1, 8, 1, 1, 0, 0, 0, 0), 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 9, 1, 0, 8, 1, 0, 0), 1, 0);
      tick();
    end
    checks++;
    if (stall_count !== 4'd1 || load_use_stall !== 1'b1) begin
      errors++;
      $display("FAIL ext_freeze_cnt: cnt=%0d stall=%b want 1/1",
               stall_count, load_use_stall);
    end
    drive(mk(1, 9, 1, 0, 8, 1, 0, 0), 0, 0);
    tick();
    tick();
    checks++;
    if (stall_count !== 4'd2) begin
      errors++;
      $display("FAIL ext_release_cnt: cnt=%0d want 2", stall_count);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      drive(mk(1, 8, 1, 1, 0, 0, 0, 0), 0, 0);
      tick();
      drive(mk(1, 9, 1, 0, 0, 0, 8, 1), 0, 0);
      tick();
      tick();
    end
    drive(nop(), 0, 0);
    checks++;
    if (stall_count !== 4'hF) begin
      errors++;
      $display("FAIL saturate: cnt=%0d want 15", stall_count);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        reset_n = 1'b0;
        #1;
        checks++;
        if (fwd_sel !== 4'b0 || load_use_stall !== 1'b0 ||
            stall_count !== '0) begin
          errors++;
          $display("FAIL rand_reset: fwd=%b stall=%b cnt=%0d",
                   fwd_sel, load_use_stall, stall_count);
        end
        tick();
        reset_n = 1'b1;
      end
      drive(rnd_ins(), $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10);
      checks++;
      if (fwd_sel !== exp_fwd() ||
          load_use_stall !== exp_stall() ||
          stall_count !== CW'(m_cnt)) begin
        errors++;
        $display("FAIL rand[%0d]: fwd=%b/%b stall=%b/%b cnt=%0d/%0d",
                 n, fwd_sel, exp_fwd(), load_use_stall,
                 exp_stall(), stall_count, m_cnt);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_alu_fwd_mem();
    test_wb_fwd_x0();
    test_load_use();
    test_youngest_wins();
    test_flush();
    test_stall_ext();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
